lfsr_period_ctrl: RTL and testbench

LFSR_PERIOD_CTRL -- requirements
Module: lfsr_period_ctrl

---
 rtl/lfsr_period_ctrl.sv | 99 +++++++++
 tb/tb_lfsr_period_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_period_ctrl.sv
// Sequencer for an external LFSR counter: loads a seed, then counts a requested
// number of terminal-count pulses, optionally reloading the seed between periods.
module lfsr_period_ctrl #(
  parameter int width = 4,
  parameter int cntw  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] seed,
  input  logic [cntw-1:0]  periods,
  input  logic             reload_each,
  input  logic             abort,
  input  logic             tercnt,
  output logic [width-1:0] lfsr_data,
  output logic             lfsr_load,
  output logic             lfsr_cen,
  output logic             busy,
  output logic             done,
  output logic [cntw-1:0]  period_cnt,
  output logic             pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [cntw-1:0] periods_q;
  logic            reload_q;
  logic            start_ok;
  logic            count_hit;
  logic [cntw-1:0] cnt_inc;

  assign start_ok = (state == IDLE) && start;
  // abort wins over a coincident tercnt; the compare also keeps period_cnt from wrapping
  assign count_hit = (state == RUN) && tercnt && !abort && (period_cnt != periods_q);
  assign cnt_inc   = period_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (periods == '0) ? DONE : LOAD;
      end
      LOAD: begin
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (count_hit) begin
          if (cnt_inc == periods_q) state_nxt = DONE;
          else if (reload_q)        state_nxt = LOAD;
          else                      state_nxt = RUN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lfsr_data  <= '0;
      periods_q  <= '0;
      reload_q   <= 1'b0;
      period_cnt <= '0;
      pulse      <= 1'b0;
    end else begin
      state <= state_nxt;
      pulse <= count_hit;
      if (start_ok) begin
        lfsr_data  <= seed;
        periods_q  <= periods;
        reload_q   <= reload_each;
        period_cnt <= '0;
      end else if (count_hit) begin
        period_cnt <= cnt_inc;
      end
    end
  end

  // Control strobes decode straight from the state register, so they follow reset at once.
  assign lfsr_load = (state != LOAD);
  assign lfsr_cen  = (state == LOAD) || (state == RUN);
  assign busy      = (state == LOAD) || (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_lfsr_period_ctrl.sv
// Directed bench for lfsr_period_ctrl: inputs change 1ns after the rising edge,
// outputs are checked at that same point against hand-computed values.
module tb_lfsr_period_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] seed;
  logic [7:0] periods;
  logic       reload_each;
  logic       abort;
  logic       tercnt;
  logic [3:0] lfsr_data;
  logic       lfsr_load;
  logic       lfsr_cen;
  logic       busy;
  logic       done;
  logic [7:0] period_cnt;
  logic       pulse;

  int n_tests;
  int n_fail;
  int load_lows;
  int done_cnt;
  int busy_seen;

  lfsr_period_ctrl #(.width(4), .cntw(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .periods    (periods),
    .reload_each(reload_each),
    .abort      (abort),
    .tercnt     (tercnt),
    .lfsr_data  (lfsr_data),
    .lfsr_load  (lfsr_load),
    .lfsr_cen   (lfsr_cen),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt),
    .pulse      (pulse)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // running event counters sampled mid-cycle; tests compare deltas
  initial begin
    load_lows = 0;
    done_cnt  = 0;
    busy_seen = 0;
  end
  always @(negedge clk) begin
    if (reset) begin
      if (!lfsr_load) load_lows++;
      if (done)       done_cnt++;
      if (busy)       busy_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] s, input logic [7:0] p, input logic r);
    seed        = s;
    periods     = p;
    reload_each = r;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic tc_pulse();
    tercnt = 1'b1;
    step();
    tercnt = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {28'd0, lfsr_data}, 32'd0);
    check({tag, "_load"}, {31'd0, lfsr_load}, 32'd1);
    check({tag, "_cen"},  {31'd0, lfsr_cen},  32'd0);
    check({tag, "_busy"}, {31'd0, busy},      32'd0);
    check({tag, "_done"}, {31'd0, done},      32'd0);
    check({tag, "_cnt"},  {24'd0, period_cnt}, 32'd0);
    check({tag, "_pulse"}, {31'd0, pulse},    32'd0);
  endtask

  initial begin
    int base_load;
    int base_done;
    int base_busy;
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b0;
    start       = 1'b0;
    seed        = '0;
    periods     = '0;
    reload_each = 1'b0;
    abort       = 1'b0;
    tercnt      = 1'b0;
    #12;
    check_reset_outputs("rst");
    reset = 1'b1;
    step();
    step();

    // periods=3, no reload
    base_load = load_lows;
    base_done = done_cnt;
    do_start(4'h9, 8'd3, 1'b0);
    check("t1_load_low", {31'd0, lfsr_load}, 32'd0);
    check("t1_data",     {28'd0, lfsr_data}, 32'h9);
    check("t1_busy",     {31'd0, busy},      32'd1);
    check("t1_cen",      {31'd0, lfsr_cen},  32'd1);
    step();
    check("t1_run_load", {31'd0, lfsr_load}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tc_pulse();
      check($sformatf("t1_cnt%0d", i), {24'd0, period_cnt}, i);
      check($sformatf("t1_pulse%0d", i), {31'd0, pulse}, 32'd1);
      if (i < 3) begin
        check($sformatf("t1_busy%0d", i), {31'd0, busy}, 32'd1);
        step();
        check($sformatf("t1_pulse_off%0d", i), {31'd0, pulse}, 32'd0);
      end
    end
    check("t1_done",      {31'd0, done},     32'd1);
    check("t1_done_busy", {31'd0, busy},     32'd0);
    check("t1_done_cen",  {31'd0, lfsr_cen}, 32'd0);
    step();
    check("t1_done_off",  {31'd0, done},     32'd0);
    check("t1_cnt_hold",  {24'd0, period_cnt}, 32'd3);
    check("t1_loads", load_lows - base_load, 32'd1);
    check("t1_dones", done_cnt - base_done,  32'd1);

    // periods=2, reload each period
    base_load = load_lows;
    base_done = done_cnt;
    do_start(4'h6, 8'd2, 1'b1);
    check("t2_load1", {31'd0, lfsr_load}, 32'd0);
    step();
    tc_pulse();
    check("t2_load2", {31'd0, lfsr_load}, 32'd0);
    check("t2_data2", {28'd0, lfsr_data}, 32'h6);
    check("t2_cnt1",  {24'd0, period_cnt}, 32'd1);
    step();
    check("t2_run",   {31'd0, lfsr_load}, 32'd1);
    tc_pulse();
    check("t2_done",  {31'd0, done}, 32'd1);
    check("t2_cnt2",  {24'd0, period_cnt}, 32'd2);
    step();
    check("t2_loads", load_lows - base_load, 32'd2);
    check("t2_dones", done_cnt - base_done,  32'd1);

    // periods=0: straight to done
    base_load = load_lows;
    base_busy = busy_seen;
    do_start(4'h3, 8'd0, 1'b0);
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    step();
    check("t3_done_off", {31'd0, done}, 32'd0);
    check("t3_loads", load_lows - base_load, 32'd0);
    check("t3_busy_cyc", busy_seen - base_busy, 32'd0);

    // periods=5; tercnt in LOAD ignored, abort with 2nd tercnt
    base_done = done_cnt;
    do_start(4'hC, 8'd5, 1'b0);
    tercnt = 1'b1;
    step();
    tercnt = 1'b0;
    check("t4_load_ign_cnt",   {24'd0, period_cnt}, 32'd0);
    check("t4_load_ign_pulse", {31'd0, pulse},      32'd0);
    tc_pulse();
    check("t4_cnt1", {24'd0, period_cnt}, 32'd1);
    abort  = 1'b1;
    tc_pulse();
    abort  = 1'b0;
    check("t4_abort_cnt",  {24'd0, period_cnt}, 32'd1);
    check("t4_abort_cen",  {31'd0, lfsr_cen},   32'd0);
    check("t4_abort_busy", {31'd0, busy},       32'd0);
    check("t4_abort_done", {31'd0, done},       32'd0);
    check("t4_abort_pulse", {31'd0, pulse},     32'd0);
    step();
    step();
    check("t4_no_done", done_cnt - base_done, 32'd0);

    // abort in IDLE and in DONE has no effect
    abort = 1'b1;
    step();
    check("t5_idle_abort_cnt", {24'd0, period_cnt}, 32'd1);
    abort = 1'b0;
    base_done = done_cnt;
    do_start(4'h2, 8'd1, 1'b0);
    step();
    tc_pulse();
    check("t5_done", {31'd0, done}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_done_abort_cnt", {24'd0, period_cnt}, 32'd1);
    check("t5_dones", done_cnt - base_done, 32'd1);

    // start during RUN ignored, then async reset mid-run
    do_start(4'h5, 8'd4, 1'b0);
    step();
    tc_pulse();
    do_start(4'hA, 8'd1, 1'b1);
    check("t6_ign_data", {28'd0, lfsr_data}, 32'h5);
    check("t6_ign_busy", {31'd0, busy},      32'd1);
    check("t6_ign_load", {31'd0, lfsr_load}, 32'd1);
    check("t6_ign_cnt",  {24'd0, period_cnt}, 32'd1);
    tc_pulse();
    check("t6_cnt2", {24'd0, period_cnt}, 32'd2);
    check("t6_still_run", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    step();
    check_reset_outputs("t6_held");
    reset = 1'b1;
    step();
    step();
    check("t6_idle_after", {31'd0, busy}, 32'd0);
    base_done = done_cnt;
    do_start(4'h3, 8'd1, 1'b0);
    check("t6_new_load", {31'd0, lfsr_load}, 32'd0);
    check("t6_new_data", {28'd0, lfsr_data}, 32'h3);
    step();
    tc_pulse();
    check("t6_new_done", {31'd0, done}, 32'd1);
    step();
    check("t6_new_dones", done_cnt - base_done, 32'd1);

    // periods=255: count all the way, no wrap
    base_done = done_cnt;
    do_start(4'hF, 8'hFF, 1'b0);
    step();
    tercnt = 1'b1;
    for (int i = 1; i <= 254; i++) step();
    check("t7_cnt254",  {24'd0, period_cnt}, 32'd254);
    check("t7_busy254", {31'd0, busy},       32'd1);
    step();
    check("t7_cnt255",  {24'd0, period_cnt}, 32'd255);
    check("t7_done",    {31'd0, done},       32'd1);
    step();
    step();
    tercnt = 1'b0;
    check("t7_no_wrap", {24'd0, period_cnt}, 32'd255);
    check("t7_dones", done_cnt - base_done, 32'd1);
    check("t7_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000ns");
    $fatal(1);
  end

endmodule
